// File: rtl/ks_sched_pkg.sv
// Shared constants, FSM state type and sizing helpers for the ks_add_sched slice.
package ks_sched_pkg;

  // Width of one adder-core step.
  localparam int unsigned NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of nibble steps needed for an operand of the given width.
  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBW;
  endfunction

  // Index width for a set of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ks_add4.sv
// Combinational 4-bit Kogge-Stone adder: carry-in folded into bit 0,
// then two generate/propagate prefix levels (span 2, span 4).
module ks_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] g0;
  logic [3:0] g1;
  logic [3:2] p1;
  logic [3:0] g2;

  // Bitwise generate/propagate.
  assign g = a & b;
  assign p = a ^ b;

  // Fold carry-in into bit 0 so every prefix group starts at the carry-in.
  assign g0 = {g[3:1], g[0] | (p[0] & cin)};

  // Level 1: combine with neighbour at distance 1.
  assign g1 = {g0[3:1] | (p[3:1] & g0[2:0]), g0[0]};
  assign p1 = p[3:2] & p[2:1];

  // Level 2: combine with group at distance 2; g2[i] is the carry out of bit i.
  assign g2 = {g1[3:2] | (p1 & g1[1:0]), g1[1:0]};

  // Sum bits use the carry into each position.
  assign sum  = p ^ {g2[2:0], cin};
  assign cout = g2[3];

endmodule

// File: rtl/ks_add_sched.sv
// Round-robin scheduler sharing one nibble-serial Kogge-Stone adder core
// among NREQ requesters; results return on a valid/ready port tagged by id.
// Optional subtract support: define KS_ADD_SCHED_SUB_EN to add the req_sub port.
module ks_add_sched
  import ks_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDW   = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef KS_ADD_SCHED_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned NIDXW = idx_width(NIB);

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic               found;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry;
  logic [NIDXW-1:0]   nib_idx;
  logic               sub_sel;
  logic               cin_load;
  logic [WIDTH-1:0]   b_sel;
  logic [NIBW-1:0]    a_nib;
  logic [NIBW-1:0]    b_nib;
  logic [NIBW-1:0]    nib_sum;
  logic               nib_cout;

  // Round-robin search: first valid requester at or after ptr, with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant is offered only while idle and out of reset; at most one bit set.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && found) begin
      req_ready[winner] = 1'b1;
    end
  end

`ifdef KS_ADD_SCHED_SUB_EN
  assign sub_sel = req_sub[winner];
`else
  assign sub_sel = 1'b0;
`endif

  // Subtract is A + ~B + 1; requester carry-in is ignored in that case.
  assign b_sel    = sub_sel ? ~req_b[32'(winner)*WIDTH +: WIDTH]
                            :  req_b[32'(winner)*WIDTH +: WIDTH];
  assign cin_load = sub_sel | req_cin[winner];

  // Current nibble of the latched operands.
  assign a_nib = a_r[32'(nib_idx)*NIBW +: NIBW];
  assign b_nib = b_r[32'(nib_idx)*NIBW +: NIBW];

  ks_add4 u_add4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Control FSM: grant/latch in IDLE, one nibble per cycle in ADD, hold result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      nib_idx   <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_r     <= req_a[32'(winner)*WIDTH +: WIDTH];
            b_r     <= b_sel;
            carry   <= cin_load;
            rsp_id  <= winner;
            nib_idx <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          rsp_sum[32'(nib_idx)*NIBW +: NIBW] <= nib_sum;
          carry <= nib_cout;
          if (nib_idx == NIDXW'(NIB - 1)) begin
            nib_idx   <= '0;
            rsp_cout  <= nib_cout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
